// File: rtl/neuron_mac_lanes.sv
// neuron_mac_lanes
//   Fixed-point neuron: out = sat(round(align(bias) + sum x[i]*w[i])),
//   with an optional ReLU chosen per request. LANES products are
//   accumulated per cycle over NUM_INPUTS/LANES beats. After that come one
//   rounding/saturation cycle and an output hold state.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     request valid
//   in_ready     high only while idle
//   relu_en      ReLU enable, sampled on accept
//   bias         signed bias, Q(B_FRAC)
//   x_flat       NUM_INPUTS signed activations, element i at [i*X_W +: X_W]
//   w_flat       NUM_INPUTS signed weights, element i at [i*W_W +: W_W]
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accept
//   out_data     signed result, Q(OUT_FRAC)
//   sat_flag     result was clipped (qualified by out_valid)
//   busy         high while a request is in flight
module neuron_mac_lanes #(
    parameter int NUM_INPUTS = 16,
    parameter int LANES      = 4,
    parameter int X_W        = 8,
    parameter int W_W        = 8,
    parameter int B_W        = 16,
    parameter int OUT_W      = 16,
    parameter int X_FRAC     = 4,
    parameter int W_FRAC     = 4,
    parameter int B_FRAC     = 8,
    parameter int OUT_FRAC   = 6,
    parameter int GUARD_BITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          relu_en,
    input  logic signed [B_W-1:0]         bias,
    input  logic [NUM_INPUTS*X_W-1:0]     x_flat,
    input  logic [NUM_INPUTS*W_W-1:0]     w_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          sat_flag,
    output logic                          busy
);

    localparam int BEATS    = NUM_INPUTS / LANES;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PFRAC    = X_FRAC + W_FRAC;
    localparam int SH       = PFRAC - OUT_FRAC;
    localparam int BSH      = PFRAC - B_FRAC;
    localparam int PW       = X_W + W_W;
    localparam int SUM_W    = PW + $clog2(NUM_INPUTS);
    localparam int BIAS_AW  = B_W + BSH;
    localparam int ACC_W    = ((SUM_W > BIAS_AW) ? SUM_W : BIAS_AW) + 1 + GUARD_BITS;
    // Half an output LSB in accumulator units; zero when no bits are dropped.
    localparam int RND_INT  = (SH > 0) ? (1 << ((SH > 0) ? SH - 1 : 0)) : 0;

    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic signed [ACC_W:0] RND_ADD = (ACC_W + 1)'(RND_INT);
    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, RND, OUT} state_t;

    state_t                       state, state_next;
    logic signed [ACC_W-1:0]      acc;
    logic [BEAT_W-1:0]            beat;
    logic [NUM_INPUTS*X_W-1:0]    x_reg;
    logic [NUM_INPUTS*W_W-1:0]    w_reg;
    logic                         relu_reg;
    logic signed [ACC_W-1:0]      lane_sum;
    logic signed [ACC_W-1:0]      bias_al;
    logic [OUT_W:0]               rnd_result;

    // Round half toward +inf, then drop SH fraction bits. One extra bit
    // keeps the rounding add from wrapping.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] ext;
        ext = {a[ACC_W-1], a} + RND_ADD;
        return ext >>> SH;
    endfunction

    function automatic logic signed [ACC_W:0] relu(input logic signed [ACC_W:0] r,
                                                    input logic en);
        return (en && (r < 0)) ? '0 : r;
    endfunction

    // Returns {sat, value} clipped to the signed OUT_W range.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
        if (r > OUT_MAX)
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        else if (r < OUT_MIN)
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        else
            return {1'b0, r[OUT_W-1:0]};
    endfunction

    assign bias_al    = {{(ACC_W - B_W){bias[B_W-1]}}, bias} <<< BSH;
    assign rnd_result = saturate(relu(round_shift(acc), relu_reg));

    // Sum of this beat's LANES full-precision products.
    always_comb begin
        logic signed [X_W-1:0] xs;
        logic signed [W_W-1:0] ws;
        logic signed [PW-1:0]  prod;
        xs       = '0;
        ws       = '0;
        prod     = '0;
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            xs       = x_reg[(int'(beat) * LANES + k) * X_W +: X_W];
            ws       = w_reg[(int'(beat) * LANES + k) * W_W +: W_W];
            prod     = xs * ws;
            lane_sum = lane_sum + {{(ACC_W - PW){prod[PW-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)            state_next = ACC;
            ACC:  if (beat == LAST_BEAT)   state_next = RND;
            RND:                           state_next = OUT;
            OUT:  if (out_ready)           state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat     <= '0;
            x_reg    <= '0;
            w_reg    <= '0;
            relu_reg <= 1'b0;
            out_data <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_reg    <= x_flat;
                    w_reg    <= w_flat;
                    relu_reg <= relu_en;
                    acc      <= bias_al;
                    beat     <= '0;
                end
                ACC: begin
                    acc  <= acc + lane_sum;
                    beat <= beat + 1'b1;
                end
                RND: begin
                    sat_flag <= rnd_result[OUT_W];
                    out_data <= rnd_result[OUT_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Directed testbench for neuron_mac_lanes at default parameters.
module tb_neuron_mac_lanes;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                relu_en;
    logic signed [15:0]  bias;
    logic [127:0]        x_flat;
    logic [127:0]        w_flat;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  out_data;
    logic                sat_flag;
    logic                busy;

    logic signed [7:0]   xa [16];
    logic signed [7:0]   wa [16];

    int n_checks;
    int n_fail;

    neuron_mac_lanes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .relu_en   (relu_en),
        .bias      (bias),
        .x_flat    (x_flat),
        .w_flat    (w_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_all(input logic signed [7:0] xv, input logic signed [7:0] wv);
        for (int i = 0; i < 16; i++) begin
            xa[i] = xv;
            wa[i] = wv;
        end
    endtask

    task automatic pack();
        for (int i = 0; i < 16; i++) begin
            x_flat[i*8 +: 8] = xa[i];
            w_flat[i*8 +: 8] = wa[i];
        end
    endtask

    // Launch one request from IDLE, check latency and in_ready, check the
    // result, then complete the output handshake.
    task automatic do_neuron(input string tag, input logic signed [15:0] b,
                             input logic relu, input logic signed [15:0] exp_d,
                             input logic exp_sat);
        int  lat;
        bit  ir_low;
        pack();
        bias      = b;
        relu_en   = relu;
        out_ready = 1'b0;
        check_val({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        x_flat    = '1;   // inputs are free to change after accept
        w_flat    = '1;
        lat       = 0;
        ir_low    = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready) ir_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) ir_low = 1'b0;
        check_val({tag, "_latency"}, lat, 5);
        check_val({tag, "_in_ready_low"}, ir_low, 1);
        check_val({tag, "_out_data"}, out_data, exp_d);
        check_val({tag, "_sat_flag"}, sat_flag, exp_sat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, out_valid, 0);
        check_val({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic signed [15:0] hold_d;
        logic               hold_s;
        bit                 seen;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        relu_en   = 1'b0;
        bias      = '0;
        x_flat    = '0;
        w_flat    = '0;
        out_ready = 1'b0;
        set_all(8'sd0, 8'sd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_sat_flag", sat_flag, 0);
        check_val("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", in_ready, 1);

        // Basic dot product: 16 * 1.0 * 1.0 = 16.0
        set_all(8'sd16, 8'sd16);
        do_neuron("t1", 16'sd0, 1'b1, 16'sd1024, 1'b0);

        // Bias alignment and ReLU
        do_neuron("t2a", -16'sd2048, 1'b1, 16'sd512, 1'b0);
        do_neuron("t2b", -16'sd8192, 1'b1, 16'sd0, 1'b0);
        do_neuron("t2c", -16'sd8192, 1'b0, -16'sd1024, 1'b0);

        // Rounding, single nonzero product
        set_all(8'sd0, 8'sd0);
        xa[0] = 8'sd1;  wa[0] = 8'sd2;
        do_neuron("t3a", 16'sd0, 1'b0, 16'sd1, 1'b0);
        xa[0] = 8'sd1;  wa[0] = 8'sd1;
        do_neuron("t3b", 16'sd0, 1'b0, 16'sd0, 1'b0);
        xa[0] = -8'sd1; wa[0] = 8'sd2;
        do_neuron("t3c", 16'sd0, 1'b0, 16'sd0, 1'b0);
        xa[0] = -8'sd1; wa[0] = 8'sd3;
        do_neuron("t3d", 16'sd0, 1'b0, -16'sd1, 1'b0);

        // Saturation both directions
        set_all(-8'sd128, -8'sd128);
        do_neuron("t4a", 16'sd0, 1'b0, 16'sd32767, 1'b1);
        set_all(-8'sd128, 8'sd127);
        do_neuron("t4b", -16'sd32768, 1'b0, -16'sd32768, 1'b1);

        // Backpressure: hold for 10 cycles with a stray in_valid
        set_all(8'sd16, 8'sd16);
        pack();
        bias     = -16'sd2048;
        relu_en  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check_val("t5_valid", out_valid, 1);
        check_val("t5_data", out_data, 512);
        hold_d   = out_data;
        hold_s   = sat_flag;
        set_all(8'sd1, 8'sd1);
        pack();
        bias     = 16'sd0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("t5_hold_valid", out_valid, 1);
            check_val("t5_hold_data", out_data, hold_d);
            check_val("t5_hold_sat", sat_flag, hold_s);
            check_val("t5_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("t5_valid_drop", out_valid, 0);
        check_val("t5_in_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        check_val("t5_no_queued_busy", busy, 0);
        check_val("t5_no_queued_valid", out_valid, 0);

        // Lane mapping: x[i] = i, w[i] = 1 -> 120 Q8 -> 30 Q6
        for (int i = 0; i < 16; i++) begin
            xa[i] = 8'(i);
            wa[i] = 8'sd1;
        end
        do_neuron("t6a", 16'sd0, 1'b0, 16'sd30, 1'b0);

        // Reset while accumulating beat 2
        set_all(8'sd16, 8'sd16);
        pack();
        bias     = 16'sd0;
        relu_en  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("t6b_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("t6b_rst_valid", out_valid, 0);
        check_val("t6b_rst_data", out_data, 0);
        check_val("t6b_rst_sat", sat_flag, 0);
        check_val("t6b_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_val("t6b_no_output", seen, 0);
        check_val("t6b_in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_mac_lanes.md
Name: neuron_mac_lanes

Overview:
Multi-lane fixed-point neuron: y = sat(round(align(bias) + sum x[i]*w[i])), with optional runtime ReLU.
- LANES multiply-accumulates per cycle over NUM_INPUTS/LANES beats.
- Proper Q-format alignment of bias and output, round-half-up, saturation flag.
- valid/ready handshakes on both input and output.
- Building block for layer engines that instantiate one per output neuron.

Parameters:
NUM_INPUTS, 16, inputs per neuron; must be a multiple of LANES
LANES, 4, parallel multipliers per cycle (1..NUM_INPUTS)
X_W, 8, signed activation width
W_W, 8, signed weight width
B_W, 16, signed bias width
OUT_W, 16, signed output width
X_FRAC, 4, activation fractional bits
W_FRAC, 4, weight fractional bits
B_FRAC, 8, bias fractional bits; must be <= X_FRAC+W_FRAC
OUT_FRAC, 6, output fractional bits; must be <= X_FRAC+W_FRAC
GUARD_BITS, 2, extra accumulator headroom

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE
relu_en  in  1  ReLU enable; sampled on accept
bias  in  B_W  signed bias, Q(B_FRAC)
x_flat  in  NUM_INPUTS*X_W  element i at bits [i*X_W +: X_W], signed Q(X_FRAC)
w_flat  in  NUM_INPUTS*W_W  element i at bits [i*W_W +: W_W], signed Q(W_FRAC)
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accept
out_data  out  OUT_W  signed result, Q(OUT_FRAC)
sat_flag  out  1  result was clipped; qualified by out_valid
busy  out  1  high in ACC, RND and OUT

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock clk. Reset values:
  - state = IDLE; out_valid = 0, out_data = 0, sat_flag = 0, busy = 0; accumulator, beat counter and operand registers = 0.
  - Reset mid-operation aborts the computation; no output is produced.
- Widths:
  - PFRAC = X_FRAC + W_FRAC; SH = PFRAC - OUT_FRAC; BSH = PFRAC - B_FRAC.
  - ACC_W = max(X_W+W_W+clog2(NUM_INPUTS), B_W+BSH) + 1 + GUARD_BITS; all arithmetic is signed.
- States and transitions (BEATS = NUM_INPUTS/LANES; accept edge counted as edge 0):
  - IDLE: on in_valid & in_ready, latch x_flat, w_flat and relu_en; set acc = sign-extended bias <<< BSH; beat = 0; go to ACC.
  - ACC: each edge, acc += sum over k = 0..LANES-1 of x[beat*LANES+k] * w[beat*LANES+k] (full-precision products, sign-extended to ACC_W). Edges 1..BEATS; after beat BEATS-1, go to RND.
  - RND (edge BEATS+1):
    - r = (acc + (SH > 0 ? 1 << (SH-1) : 0)) >>> SH (round half toward +inf).
    - If relu_en and r < 0, r = 0.
    - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; set sat_flag if clipped.
    - Register out_data and sat_flag; out_valid = 1; go to OUT.
  - OUT: hold out_data, sat_flag and out_valid stable while out_ready = 0. On an edge with out_ready = 1: out_valid = 0, go to IDLE.
- Latency and throughput:
  - out_valid is high after edge BEATS+1 (5 edges at defaults).
  - in_ready returns on the cycle after the output handshake, giving a minimum of BEATS+3 cycles per neuron.
- Input handshake: in_ready is a pure function of state (IDLE). in_valid while not IDLE is ignored; inputs are not queued. Input values change freely after accept.
- Output handshake: out_ready while out_valid = 0 has no effect.
- LANES = NUM_INPUTS: single accumulate beat. SH = 0: no rounding term. BSH = 0: no bias shift.

Test Plan:
1. Defaults; all x = 16, all w = 16 (1.0 each), bias = 0, relu_en = 1 -> out_data = 1024 (16.0), sat_flag = 0; out_valid after edge 5; in_ready low on edges 1..6.
2. Bias and ReLU, same x/w as 1:
   - bias = -2048 -> 512.
   - bias = -8192, relu_en = 1 -> 0.
   - bias = -8192, relu_en = 0 -> -1024.
3. Rounding, relu_en = 0, only x[0], w[0] nonzero:
   - (1, 2) -> 1.
   - (1, 1) -> 0.
   - (-1, 2) -> 0 (ties go up).
   - (-1, 3) -> -1.
4. Saturation, relu_en = 0:
   - all x = -128, w = -128 -> 32767, sat_flag = 1.
   - all x = -128, w = 127, bias = -32768 -> -32768, sat_flag = 1.
5. Backpressure: hold out_ready = 0 for 10 cycles -> out_valid, out_data and sat_flag stable, in_ready = 0, a new in_valid is ignored. Then out_ready = 1 -> out_valid drops next edge and in_ready = 1.
6. Lane mapping and reset:
   - x[i] = i, w[i] = 1 -> sum 120 -> out_data = 30.
   - Assert rst_n = 0 during ACC beat 2 -> all outputs 0 immediately; no out_valid after release.
